// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: IF/ID register plus B/BR resolution against {Z,V,N}; ins clk/rst/stall, fetch PC/inst/prediction, flags, br_reg_data; outs IF_ID_* fields, resolve results to fetch, saturating branch/mispredict counters
module branch_resolve_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [15:0]      PC_curr,
  input  logic [15:0]      PC_next,
  input  logic [15:0]      PC_inst,
  input  logic             predicted_taken,
  input  logic [15:0]      predicted_target,
  input  logic [2:0]       flags,
  input  logic [15:0]      br_reg_data,
  output logic [3:0]       IF_ID_PC_curr,
  output logic [15:0]      IF_ID_PC_next,
  output logic [15:0]      IF_ID_inst,
  output logic             was_branch,
  output logic             actual_taken,
  output logic [15:0]      actual_target,
  output logic             branch_mispredicted,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);
  logic        if_id_valid;
  logic        if_id_pred_taken;
  logic [15:0] if_id_pred_target;
  logic        is_b, is_br, res, cond, z, v, n;
  logic [7:0]  cond_vec;
  assign {z, v, n}  = flags;
  assign is_b       = IF_ID_inst[15:12] == 4'hC;
  assign is_br      = IF_ID_inst[15:12] == 4'hD;
  assign res        = if_id_valid & ~stall & (is_b | is_br);
  assign cond_vec   = {1'b1, v, n | z, z | ~n, n, ~z & ~n, z, ~z};
  assign cond       = cond_vec[IF_ID_inst[11:9]];
  assign was_branch = res;
  assign actual_taken  = res & cond;
  assign actual_target = is_b  ? IF_ID_PC_next + {{6{IF_ID_inst[8]}}, IF_ID_inst[8:0], 1'b0} :
                         is_br ? br_reg_data : IF_ID_PC_next;
  assign branch_mispredicted = res & ((actual_taken != if_id_pred_taken) |
                               (actual_taken & if_id_pred_taken & (actual_target != if_id_pred_target)));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_valid       <= 1'b0;
      IF_ID_inst        <= 16'h0000;
      IF_ID_PC_curr     <= 4'h0;
      IF_ID_PC_next     <= 16'h0000;
      if_id_pred_taken  <= 1'b0;
      if_id_pred_target <= 16'h0000;
      branch_cnt        <= '0;
      mispredict_cnt    <= '0;
    end else begin
      if (!stall) begin
        IF_ID_PC_curr     <= PC_curr[3:0];
        IF_ID_PC_next     <= PC_next;
        if_id_pred_target <= predicted_target;
        if_id_valid       <= ~branch_mispredicted;
        IF_ID_inst        <= branch_mispredicted ? 16'h0000 : PC_inst;
        if_id_pred_taken  <= ~branch_mispredicted & predicted_taken;
      end
      if (res && !(&branch_cnt)) branch_cnt <= branch_cnt + CNT_W'(1);
      if (branch_mispredicted && !(&mispredict_cnt)) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and random checks of branch_resolve_unit against a spec-level model
module tb_branch_resolve_unit;
  localparam int W = 4;
  localparam int CMAX = (1 << W) - 1;
  logic clk = 0, rst = 1, stall = 0, pt = 0;
  logic [15:0] pc_curr = 0, pc_next = 0, pc_inst = 0, ptgt = 0, brd = 0;
  logic [2:0] flags = 0;
  logic [3:0] if_id_pc_curr;
  logic [15:0] if_id_pc_next, if_id_inst, actual_target;
  logic was_branch, actual_taken, branch_mispredicted;
  logic [W-1:0] branch_cnt, mispredict_cnt;
  int total = 0, passed = 0;
  bit m_valid, m_pt;
  logic [3:0] m_pc_curr;
  logic [15:0] m_pc_next, m_inst, m_ptgt;
  int m_bc, m_mc;
  bit e_res, e_taken, e_mis;
  logic [15:0] e_tgt;

  branch_resolve_unit #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .PC_curr(pc_curr), .PC_next(pc_next),
    .PC_inst(pc_inst), .predicted_taken(pt), .predicted_target(ptgt), .flags(flags),
    .br_reg_data(brd), .IF_ID_PC_curr(if_id_pc_curr), .IF_ID_PC_next(if_id_pc_next),
    .IF_ID_inst(if_id_inst), .was_branch(was_branch), .actual_taken(actual_taken),
    .actual_target(actual_target), .branch_mispredicted(branch_mispredicted),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_valid = 0; m_pt = 0; m_pc_curr = 0; m_pc_next = 0; m_inst = 0; m_ptgt = 0;
    m_bc = 0; m_mc = 0;
  endtask

  task automatic eval_model();
    bit z, v, n, c, is_b, is_br;
    z = flags[2]; v = flags[1]; n = flags[0];
    is_b  = m_inst[15:12] == 4'hC;
    is_br = m_inst[15:12] == 4'hD;
    case (m_inst[11:9])
      3'd0: c = !z;
      3'd1: c = z;
      3'd2: c = !z && !n;
      3'd3: c = n;
      3'd4: c = z || (!z && !n);
      3'd5: c = n || z;
      3'd6: c = v;
      default: c = 1;
    endcase
    e_res   = m_valid && !stall && (is_b || is_br);
    e_taken = e_res && c;
    if (is_b) e_tgt = 16'(int'(m_pc_next) + 2 * int'($signed(m_inst[8:0])));
    else if (is_br) e_tgt = brd;
    else e_tgt = m_pc_next;
    e_mis = e_res && ((e_taken != m_pt) || (e_taken && m_pt && e_tgt != m_ptgt));
  endtask

  task automatic check_all(input string tag);
    eval_model();
    chk({tag, ".pc_curr"}, 32'(if_id_pc_curr), 32'(m_pc_curr));
    chk({tag, ".pc_next"}, 32'(if_id_pc_next), 32'(m_pc_next));
    chk({tag, ".inst"}, 32'(if_id_inst), 32'(m_inst));
    chk({tag, ".was_branch"}, 32'(was_branch), 32'(e_res));
    chk({tag, ".taken"}, 32'(actual_taken), 32'(e_taken));
    chk({tag, ".target"}, 32'(actual_target), 32'(e_tgt));
    chk({tag, ".mispred"}, 32'(branch_mispredicted), 32'(e_mis));
    chk({tag, ".bcnt"}, 32'(branch_cnt), 32'(m_bc));
    chk({tag, ".mcnt"}, 32'(mispredict_cnt), 32'(m_mc));
  endtask

  task automatic step(input string tag, input logic s, input logic [15:0] pcc, input logic [15:0] pcn,
                      input logic [15:0] ins, input logic p, input logic [15:0] pg,
                      input logic [2:0] f, input logic [15:0] b);
    stall = s; pc_curr = pcc; pc_next = pcn; pc_inst = ins; pt = p; ptgt = pg; flags = f; brd = b;
    #1;
    check_all(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (!stall) begin
        m_pc_curr = pc_curr[3:0];
        m_pc_next = pc_next;
        m_ptgt    = ptgt;
        m_valid   = !e_mis;
        m_inst    = e_mis ? 16'h0000 : pc_inst;
        m_pt      = !e_mis && pt;
      end
      if (e_res) m_bc = m_bc < CMAX ? m_bc + 1 : CMAX;
      if (e_mis) m_mc = m_mc < CMAX ? m_mc + 1 : CMAX;
    end
    #1;
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    check_all("reset");
    rst = 0;
    step("b_ne_load", 0, 16'h000E, 16'h0010, 16'hC005, 0, 16'h0000, 3'b000, 16'h0000);
    tick();
    step("b_ne", 0, 16'h0010, 16'h0012, 16'h1000, 0, 16'h0000, 3'b000, 16'h0000);
    chk("b_ne_taken", 32'(actual_taken), 32'd1);
    chk("b_ne_target", 32'(actual_target), 32'h001A);
    chk("b_ne_mispred", 32'(branch_mispredicted), 32'd1);
    tick();
    step("b_eq_load", 0, 16'h001E, 16'h0020, 16'hC3FE, 1, 16'h001C, 3'b000, 16'h0000);
    chk("flush_inst", 32'(if_id_inst), 32'h0000);
    chk("flush_mcnt", 32'(mispredict_cnt), 32'd1);
    tick();
    step("b_eq", 0, 16'h0020, 16'h0022, 16'hDE30, 1, 16'h0080, 3'b100, 16'h0000);
    chk("b_eq_target", 32'(actual_target), 32'h001C);
    chk("b_eq_mispred", 32'(branch_mispredicted), 32'd0);
    tick();
    step("br_un", 0, 16'h0022, 16'h0024, 16'h3000, 0, 16'h0000, 3'b000, 16'h0100);
    chk("b_eq_noflush", 32'(if_id_inst), 32'hDE30);
    chk("b_eq_bcnt", 32'(branch_cnt), 32'd2);
    chk("br_un_taken", 32'(actual_taken), 32'd1);
    chk("br_un_target", 32'(actual_target), 32'h0100);
    chk("br_un_mispred", 32'(branch_mispredicted), 32'd1);
    tick();
    step("stall_load", 0, 16'h003E, 16'h0040, 16'hC005, 0, 16'h0000, 3'b000, 16'h0000);
    tick();
    for (int i = 0; i < 3; i++) begin
      step("stall", 1, 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 16'($urandom), 3'b000, 16'($urandom));
      chk("stall_wb", 32'(was_branch), 32'd0);
      chk("stall_bcnt", 32'(branch_cnt), 32'd3);
      tick();
    end
    step("stall_rel", 0, 16'h0040, 16'h0042, 16'h1000, 1, 16'h0000, 3'b000, 16'h0000);
    chk("stall_rel_wb", 32'(was_branch), 32'd1);
    tick();
    step("alias", 0, 16'h0042, 16'h0044, 16'h2000, 0, 16'h0000, 3'b000, 16'h0000);
    chk("stall_rel_bcnt", 32'(branch_cnt), 32'd4);
    tick();
    step("alias_chk", 0, 16'h0044, 16'h0046, 16'h2000, 0, 16'h0000, 3'b000, 16'h0000);
    chk("alias_mispred", 32'(branch_mispredicted), 32'd0);
    tick();
    for (int i = 0; i < 300; i++) begin
      logic [15:0] ins, b, g;
      ins = 16'($urandom);
      if ($urandom_range(1, 0) == 1) ins[15:12] = $urandom_range(1, 0) == 1 ? 4'hC : 4'hD;
      b = $urandom_range(1, 0) == 1 ? 16'h0100 : 16'h0200;
      g = $urandom_range(1, 0) == 1 ? 16'h0100 : 16'($urandom);
      step("rand", 1'($urandom_range(4, 0) == 0), 16'($urandom), 16'($urandom), ins,
           1'($urandom), g, 3'($urandom), b);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      step("sat", 0, 16'h000E, 16'h0010, 16'hC005, 0, 16'h0000, 3'b000, 16'h0000);
      tick();
    end
    step("sat_end", 0, 16'h000E, 16'h0010, 16'h1000, 0, 16'h0000, 3'b000, 16'h0000);
    chk("sat_bcnt", 32'(branch_cnt), 32'(CMAX));
    chk("sat_mcnt", 32'(mispredict_cnt), 32'(CMAX));
    tick();
    step("pre_rst", 0, 16'h0012, 16'h0014, 16'hC005, 1, 16'h0055, 3'b101, 16'h0000);
    tick();
    #2 rst = 1;
    #1 model_reset();
    check_all("async_rst");
    chk("async_rst_inst", 32'(if_id_inst), 32'h0000);
    chk("async_rst_bcnt", 32'(branch_cnt), 32'd0);
    tick();
    #2 rst = 0;
    step("post_rst", 0, 16'h0030, 16'h0032, 16'hC005, 0, 16'h0000, 3'b000, 16'h0000);
    tick();
    step("post_rst_chk", 0, 16'h0032, 16'h0034, 16'h1000, 0, 16'h0000, 3'b001, 16'h0000);
    chk("post_rst_inst", 32'(if_id_inst), 32'hC005);
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Decode-side end of the fetch/branch-prediction interface.
- Holds the IF/ID pipeline register: PC, PC+2, instruction, predicted_taken, predicted_target.
- Decodes B/BR in decode and evaluates the condition against the flags.
- Produces actual_taken, actual_target, was_branch, branch_mispredicted and IF_ID_PC_curr back to fetch, and counts branch statistics.

Parameters:
- CNT_W, 16, width of the saturating branch and mispredict counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- stall  in  1  hazard-unit stall; holds IF/ID and suppresses resolution
- PC_curr  in  16  fetch-stage current PC
- PC_next  in  16  fetch-stage PC+2
- PC_inst  in  16  fetched instruction
- predicted_taken  in  1  fetch prediction
- predicted_target  in  16  fetch BTB target
- flags  in  3  {Z,V,N} from the flag register
- br_reg_data  in  16  rs value for BR, already forwarded
- IF_ID_PC_curr  out  4  registered PC_curr[3:0], for BHT/BTB update index
- IF_ID_PC_next  out  16  registered PC+2
- IF_ID_inst  out  16  registered instruction
- was_branch  out  1  a valid B/BR resolves this cycle
- actual_taken  out  1  resolved direction
- actual_target  out  16  resolved target
- branch_mispredicted  out  1  fetch must redirect
- branch_cnt  out  CNT_W  resolved-branch count
- mispredict_cnt  out  CNT_W  misprediction count

Behaviour:
- Reset (async, immediate):
  - IF/ID valid=0, IF_ID_inst=16'h0000, all registered PC fields 0, pred fields 0.
  - Counters 0.
  - All combinational outputs therefore 0.
- IF/ID register update each clk edge, in priority order:
  - stall=1: hold all fields.
  - else branch_mispredicted=1: flush (valid=0, inst=16'h0000, pred_taken=0; PC fields still load).
  - else: load inputs, valid=1.
- Decode, from registered contents only (same cycle, zero latency):
  - is_B = inst[15:12]==4'hC; is_BR = inst[15:12]==4'hD.
  - res = valid & ~stall & (is_B|is_BR).
  - was_branch = res.
  - ccc = inst[11:9]; Z=flags[2], V=flags[1], N=flags[0].
- Condition codes:
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z&~N
  - 011 LT: N
  - 100 GTE: Z|(~Z&~N)
  - 101 LTE: N|Z
  - 110 OV: V
  - 111 UN: 1
- actual_taken = res & cond.
- actual_target:
  - is_B: IF_ID_PC_next + ({{7{inst[8]}},inst[8:0]} << 1), mod 2^16, wrap ignored.
  - is_BR: br_reg_data.
  - Otherwise IF_ID_PC_next.
- branch_mispredicted = res & ((actual_taken != pred_taken) | (actual_taken & pred_taken & (actual_target != pred_target))).
- Non-branch in IF/ID with pred_taken=1 (BTB alias): no mispredict signalled; recovery is not this block's job.
- Counters, on the edge of any res cycle:
  - branch_cnt += 1.
  - mispredict_cnt += 1 if branch_mispredicted.
  - Both saturate at all-ones, no wrap.
- Simultaneous stall and resolvable branch: no resolution and no count; the branch resolves on the first non-stalled cycle.
- A flushed slot (valid=0) never resolves, even if its inst bits decode as a branch.
- Reset mid-flush or mid-stall: state cleared at once; the first post-reset edge loads normally.

Test Plan:
- Reset asserted asynchronously mid-cycle -> all outputs 0 before the next edge; counters 0.
- B NE (inst 16'hC005), IF_ID_PC_next=16'h0010, Z=0, pred_taken=0:
  - Decode cycle: actual_taken=1, actual_target=16'h001A, branch_mispredicted=1.
  - Next edge: IF/ID flushed (inst=0000); mispredict_cnt=1.
- B EQ (16'hC3FE), PC_next=16'h0020, Z=1, pred_taken=1, pred_target=16'h001C -> target 16'h001C, mispredicted=0, branch_cnt increments, no flush.
- BR UN (16'hDE30), br_reg_data=16'h0100, pred_taken=1, pred_target=16'h0080 -> taken, target 16'h0100, mispredicted=1 (target mismatch).
- Stall held 3 cycles with B in IF/ID -> was_branch=0 and counters unchanged throughout; on release, resolves once and branch_cnt +1.
- Preload both counters near all-ones (run 2^CNT_W mispredicting branches, or CNT_W=4 with 20) -> both stick at all-ones.
